// File: rtl/gf2m_reduce_571.sv
// rtl/gf2m_reduce_571.sv - digit-serial reducer of a 1142-bit carry-less product modulo x^571+x^10+x^5+x^2+1
module gf2m_reduce_571 #(
    parameter int DIGIT = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1141:0] c_in,
    output logic          busy,
    output logic          done,
    output logic [570:0]  r
);
    localparam int M    = 571;
    localparam int W    = 2 * M;
    localparam int NCYC = (M + DIGIT - 1) / DIGIT;
    localparam int CW   = $clog2(NCYC + 1);

    if (DIGIT < 1 || DIGIT > 64) begin : g_bad_digit
        $error("gf2m_reduce_571: DIGIT must be in 1..64");
    end

    typedef enum logic [1:0] {S_IDLE, S_FOLD, S_OUT} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [10:0]     ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [M-1:0]    r_q, r_d;

    logic [10:0]     base;
    logic [10:0]     pos;
    logic [DIGIT-1:0] digit;
    logic [W-1:0]    clr;
    logic [W-1:0]    fold;

    // Every folded bit k sits at or above 571 and its targets land at or below
    // k-561, which is always below the current digit, so one digit folds at once.
    always_comb begin
        base  = ptr_q - 11'(DIGIT - 1);
        pos   = '0;
        digit = '0;
        for (int j = 0; j < DIGIT; j++) begin
            pos      = base + 11'(j);
            digit[j] = (pos >= 11'(M)) ? acc_q[pos] : 1'b0;
        end
        clr  = {{(W - DIGIT){1'b0}}, digit} << base;
        fold = acc_q ^ clr ^ (clr >> M) ^ (clr >> (M - 2)) ^ (clr >> (M - 5)) ^ (clr >> (M - 10));
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        r_d     = r_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = c_in;
                    ptr_d   = 11'(W - 1);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                acc_d = fold;
                ptr_d = ptr_q - 11'(DIGIT);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NCYC - 1)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                r_d     = acc_q[M-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ptr_q   <= 11'(W - 1);
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            r_q     <= r_d;
        end
    end

    // The high half must be fully folded away by the time the result is taken.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_OUT) begin
            assert (acc_q[W-1:M] == '0);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign r    = r_q;
endmodule

// File: tb/tb_gf2m_reduce_571.sv
// tb/tb_gf2m_reduce_571.sv - directed and golden-model checks of gf2m_reduce_571 at DIGIT=32 with 1/7/64 companions
module tb_gf2m_reduce_571;
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1141:0] c_in;
    logic          busy, done;
    logic [570:0]  r;

    logic          x_busy [3];
    logic          x_done [3];
    logic [570:0]  x_r    [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gf2m_reduce_571 #(.DIGIT(32)) u_dut (
        .clk(clk), .rst(rst), .start(start), .c_in(c_in),
        .busy(busy), .done(done), .r(r)
    );

    for (genvar g = 0; g < 3; g++) begin : g_x
        gf2m_reduce_571 #(.DIGIT(g == 0 ? 1 : (g == 1 ? 7 : 64))) u_x (
            .clk(clk), .rst(rst), .start(start), .c_in(c_in),
            .busy(x_busy[g]), .done(x_done[g]), .r(x_r[g])
        );
    end

    task automatic check(input string tag, input logic [1141:0] got, input logic [1141:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [570:0] gold(input logic [1141:0] c);
        logic [1141:0] a;
        a = c;
        for (int k = 1141; k >= 571; k--) begin
            if (a[k]) begin
                a[k]       = 1'b0;
                a[k - 571] = ~a[k - 571];
                a[k - 569] = ~a[k - 569];
                a[k - 566] = ~a[k - 566];
                a[k - 561] = ~a[k - 561];
            end
        end
        return a[570:0];
    endfunction

    function automatic logic [1141:0] clmul(input logic [570:0] a, input logic [570:0] b);
        logic [1141:0] p;
        p = '0;
        for (int i = 0; i < 571; i++) begin
            if (b[i]) p = p ^ ({571'b0, a} << i);
        end
        return p;
    endfunction

    function automatic logic [1141:0] rnd();
        logic [1151:0] t;
        for (int i = 0; i < 36; i++) t[i*32 +: 32] = $urandom();
        return t[1141:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_all_idle();
        int n;
        n = 0;
        while ((busy || x_busy[0] || x_busy[1] || x_busy[2]) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) check("idle_timeout", 1, 0);
    endtask

    // Pulse start, then count edges to done and cycles with busy high.
    task automatic run(input logic [1141:0] c, output logic [570:0] res, output int lat, output int bcnt);
        c_in  = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
            if (busy) bcnt++;
        end
        if (!done) check("done_timeout", 0, 1);
        res = r;
        wait_all_idle();
    endtask

    task automatic run_gold(input string tag, input logic [1141:0] c);
        logic [570:0] res;
        logic [570:0] g;
        int lat, bcnt;
        g = gold(c);
        run(c, res, lat, bcnt);
        check({tag, "_d32"}, {571'b0, res}, {571'b0, g});
        check({tag, "_d1"},  {571'b0, x_r[0]}, {571'b0, g});
        check({tag, "_d7"},  {571'b0, x_r[1]}, {571'b0, g});
        check({tag, "_d64"}, {571'b0, x_r[2]}, {571'b0, g});
    endtask

    initial begin
        logic [570:0]  res;
        logic [570:0]  a, b;
        logic [1141:0] v;
        logic [1141:0] vec [4];
        int lat, bcnt, ndone, n, last;

        rst = 1'b1; start = 1'b0; c_in = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_busy", {1141'b0, busy}, 0);
        check("rst_done", {1141'b0, done}, 0);
        check("rst_r", {571'b0, r}, 0);

        run('0, res, lat, bcnt);
        check("zero_lat", lat, 19);
        check("zero_busy", bcnt, 19);
        check("zero_r", {571'b0, res}, 0);

        v = '0; v[571] = 1'b1;
        run(v, res, lat, bcnt);
        check("x571", {571'b0, res}, 1142'h425);
        check("x571_d1", {571'b0, x_r[0]}, 1142'h425);

        v = '0; v[1141] = 1'b1;
        run(v, res, lat, bcnt);
        v = '0; v[570] = 1'b1; v[19:0] = 20'h8001A;
        check("x1141", {571'b0, res}, v);
        check("x1141_d7", {571'b0, x_r[1]}, v);
        check("x1141_d64", {571'b0, x_r[2]}, v);

        // Low half only; extra starts while busy must be ignored.
        v = rnd(); v[1141:571] = '0;
        c_in = v; start = 1'b1;
        tick();
        start = 1'b0; ndone = 0; lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 3 || i == 10) begin start = 1'b1; c_in = rnd(); end
            tick();
            start = 1'b0;
            if (done) begin ndone++; lat = i; res = r; end
        end
        check("ign_ndone", ndone, 1);
        check("ign_lat", lat, 19);
        check("ign_r", {571'b0, res}, {571'b0, v[570:0]});
        wait_all_idle();

        // Reset mid-fold aborts without a done.
        c_in = rnd(); start = 1'b1;
        tick();
        start = 1'b0; ndone = 0;
        for (int i = 1; i <= 30; i++) begin
            rst = (i == 7);
            tick();
            if (done) ndone++;
        end
        rst = 1'b0;
        check("abort_ndone", ndone, 0);
        check("abort_r", {571'b0, r}, 0);
        check("abort_busy", {1141'b0, busy}, 0);
        v = rnd();
        run(v, res, lat, bcnt);
        check("after_abort", {571'b0, res}, {571'b0, gold(v)});
        check("after_abort_lat", lat, 19);

        for (int i = 0; i < 6; i++) run_gold("rand", rnd());

        // Chained operands through a software multiplier.
        a = rnd(); b = rnd();
        for (int i = 0; i < 3; i++) begin
            v = clmul(a, b);
            run_gold("chain", v);
            a = gold(v);
        end

        // Back-to-back with start held high.
        for (int i = 0; i < 4; i++) vec[i] = rnd();
        c_in = vec[0]; start = 1'b1;
        tick();
        n = 0; last = 0; ndone = 0;
        for (int i = 1; i <= 100 && ndone < 4; i++) begin
            tick();
            if (done) begin
                check("b2b_r", {571'b0, r}, {571'b0, gold(vec[ndone])});
                if (ndone > 0) check("b2b_gap", i - last, 20);
                last = i;
                ndone++;
                if (ndone < 4) c_in = vec[ndone];
            end
        end
        check("b2b_count", ndone, 4);
        start = 1'b0;
        wait_all_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
